// File: rtl/actor_mover.sv
// actor_mover: tile-maze actor movement and mouth-animation controller.
// Latches a requested direction, turns only at tile alignment (reversal
// allowed anywhere), steps once per frame tick against the open-direction
// mask, wraps through the side tunnel, and drives sprite index and pixel hit.
module actor_mover #(
    parameter int W          = 10,
    parameter int START_X    = 228,
    parameter int START_Y    = 336,
    parameter int SIZE       = 24,
    parameter int Y_OFF      = 6,
    parameter int STEP       = 1,
    parameter int TILE_LOG2  = 2,
    parameter int ANIM_LEN   = 9,
    parameter int CLOSED_END = 2,
    parameter int OPEN_START = 4,
    parameter int OPEN_END   = 7,
    parameter int BLOCK_FRAME = 2,
    parameter int WRAP_LO    = 72,
    parameter int WRAP_HI    = 408
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_tick,
    input  logic         freeze,
    input  logic [2:0]   req_dir,
    input  logic [3:0]   avail_dir,
    input  logic [W-1:0] draw_x,
    input  logic [W-1:0] draw_y,
    output logic [W-1:0] pos_x,
    output logic [W-1:0] pos_y,
    output logic [2:0]   cur_dir,
    output logic [3:0]   anim_frame,
    output logic [3:0]   sprite_idx,
    output logic         moving,
    output logic         is_actor
);
    // Two extra bits give headroom for sign and for x+SIZE overshoot.
    localparam int XW = W + 2;
    localparam logic signed [XW-1:0] STEP_S    = XW'(STEP);
    localparam logic signed [XW-1:0] SIZE_S    = XW'(SIZE);
    localparam logic signed [XW-1:0] Y_OFF_S   = XW'(Y_OFF);
    localparam logic signed [XW-1:0] WRAP_LO_S = XW'(WRAP_LO);
    localparam logic signed [XW-1:0] WRAP_HI_S = XW'(WRAP_HI);
    localparam logic signed [XW-1:0] WRAP_IN_S = XW'(WRAP_LO - SIZE);
    localparam logic [3:0] ANIM_LAST = 4'(ANIM_LEN - 1);
    localparam logic [3:0] CLOSED_E  = 4'(CLOSED_END);
    localparam logic [3:0] OPEN_S    = 4'(OPEN_START);
    localparam logic [3:0] OPEN_E    = 4'(OPEN_END);
    localparam logic [3:0] BLOCK_F   = 4'(BLOCK_FRAME);

    logic [2:0]           pend_dir;
    logic                 aligned;
    logic                 turn;
    logic                 can_move;
    logic [2:0]           eff_dir;
    logic signed [XW-1:0] step_x;
    logic signed [XW-1:0] step_y;
    logic signed [XW-1:0] wrap_x;
    logic [3:0]           next_anim;
    logic signed [XW-1:0] rel_x;
    logic signed [XW-1:0] rel_y;
    logic signed [XW-1:0] abs_x;
    logic [3:0]           dir_base;

    // Open-mask lookup for a direction code; codes outside 1..4 are never open.
    function automatic logic dir_open(input logic [2:0] d, input logic [3:0] avail);
        case (d)
            3'd1:    return avail[0];
            3'd2:    return avail[1];
            3'd3:    return avail[2];
            3'd4:    return avail[3];
            default: return 1'b0;
        endcase
    endfunction

    // Opposite direction: left<->right, up<->down.
    function automatic logic [2:0] reverse_dir(input logic [2:0] d);
        case (d)
            3'd1:    return 3'd3;
            3'd2:    return 3'd4;
            3'd3:    return 3'd1;
            3'd4:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    // Turn decision, step, tunnel wrap and next animation frame.
    always_comb begin
        aligned  = (pos_x[TILE_LOG2-1:0] == '0) && (pos_y[TILE_LOG2-1:0] == '0);
        turn     = (pend_dir != 3'd0) && (pend_dir != cur_dir) &&
                   dir_open(pend_dir, avail_dir) &&
                   (aligned || (pend_dir == reverse_dir(cur_dir)));
        eff_dir  = turn ? pend_dir : cur_dir;
        can_move = (eff_dir != 3'd0) && dir_open(eff_dir, avail_dir);

        step_x = $signed({2'b00, pos_x});
        step_y = $signed({2'b00, pos_y});
        if (can_move) begin
            case (eff_dir)
                3'd1:    step_x = step_x - STEP_S;
                3'd2:    step_y = step_y - STEP_S;
                3'd3:    step_x = step_x + STEP_S;
                3'd4:    step_y = step_y + STEP_S;
                default: ;
            endcase
        end

        wrap_x = step_x;
        if (step_x + SIZE_S < WRAP_LO_S)
            wrap_x = WRAP_HI_S;
        else if (step_x > WRAP_HI_S + SIZE_S)
            wrap_x = WRAP_IN_S;

        next_anim = anim_frame;
        if (turn || (!can_move && eff_dir != 3'd0))
            next_anim = BLOCK_F;
        else if (can_move)
            next_anim = (anim_frame == ANIM_LAST) ? 4'd0 : anim_frame + 4'd1;
    end

    // Actor state: reset, per-tick motion update, and request latch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pos_x      <= W'(START_X);
            pos_y      <= W'(START_Y);
            cur_dir    <= 3'd0;
            pend_dir   <= 3'd0;
            anim_frame <= 4'd0;
            moving     <= 1'b0;
        end else begin
            if (frame_tick && !freeze) begin
                if (turn) begin
                    cur_dir  <= pend_dir;
                    pend_dir <= 3'd0;
                end
                pos_x      <= wrap_x[W-1:0];
                pos_y      <= step_y[W-1:0];
                moving     <= can_move;
                anim_frame <= next_anim;
            end
            // A fresh request overrides the turn-clear above.
            if (req_dir >= 3'd1 && req_dir <= 3'd4)
                pend_dir <= req_dir;
        end
    end

    // Sprite index from direction and mouth phase of the current frame.
    always_comb begin
        dir_base = 4'd0;
        case (cur_dir)
            3'd2:    dir_base = 4'd1;
            3'd3:    dir_base = 4'd4;
            3'd4:    dir_base = 4'd5;
            default: dir_base = 4'd0;
        endcase
        if (cur_dir == 3'd0 || anim_frame < CLOSED_E)
            sprite_idx = 4'd8;
        else if (anim_frame >= OPEN_S && anim_frame < OPEN_E)
            sprite_idx = dir_base;
        else
            sprite_idx = dir_base + 4'd2;
    end

    // Pixel hit test in signed arithmetic so negative offsets never alias.
    always_comb begin
        abs_x    = $signed({2'b00, draw_x});
        rel_x    = abs_x - $signed({2'b00, pos_x});
        rel_y    = $signed({2'b00, draw_y}) - $signed({2'b00, pos_y}) - Y_OFF_S;
        is_actor = (rel_y >= 0) && (rel_y < SIZE_S) &&
                   (rel_x >= 0) && (rel_x < SIZE_S) &&
                   (abs_x >= WRAP_LO_S) && (abs_x < WRAP_HI_S);
    end
endmodule

// File: tb/tb_actor_mover.sv
// tb_actor_mover: directed vectors with hand-computed expectations.
module tb_actor_mover;
    localparam int W = 10;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         frame_tick = 1'b0;
    logic         freeze = 1'b0;
    logic [2:0]   req_dir = 3'd0;
    logic [3:0]   avail_dir = 4'b0000;
    logic [W-1:0] draw_x = '0;
    logic [W-1:0] draw_y = '0;
    logic [W-1:0] pos_x;
    logic [W-1:0] pos_y;
    logic [2:0]   cur_dir;
    logic [3:0]   anim_frame;
    logic [3:0]   sprite_idx;
    logic         moving;
    logic         is_actor;

    int checks = 0;
    int failures = 0;

    actor_mover dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .freeze     (freeze),
        .req_dir    (req_dir),
        .avail_dir  (avail_dir),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .cur_dir    (cur_dir),
        .anim_frame (anim_frame),
        .sprite_idx (sprite_idx),
        .moving     (moving),
        .is_actor   (is_actor)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk) Reset = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk) frame_tick = 1'b1;
            @(negedge Clk) frame_tick = 1'b0;
        end
    endtask

    task automatic request(input logic [2:0] d);
        @(negedge Clk) req_dir = d;
        @(negedge Clk) req_dir = 3'd0;
    endtask

    task automatic probe(input int x, input int y, input int exp, input string tag);
        draw_x = W'(x);
        draw_y = W'(y);
        #1 check_val(tag, int'(is_actor), exp);
    endtask

    initial begin
        // Reset state and hit test at the start position
        do_reset();
        check_val("rst_x", int'(pos_x), 228);
        check_val("rst_y", int'(pos_y), 336);
        check_val("rst_dir", int'(cur_dir), 0);
        check_val("rst_anim", int'(anim_frame), 0);
        check_val("rst_moving", int'(moving), 0);
        check_val("rst_sprite", int'(sprite_idx), 8);
        probe(228, 342, 1, "hit_origin");
        probe(251, 365, 1, "hit_corner");
        probe(252, 342, 0, "miss_right");
        probe(228, 341, 0, "miss_above");

        // First move left from rest
        avail_dir = 4'b0101;
        request(3'd1);
        tick(1);
        check_val("start_dir", int'(cur_dir), 1);
        check_val("start_x", int'(pos_x), 227);
        check_val("start_anim", int'(anim_frame), 2);
        check_val("start_moving", int'(moving), 1);
        tick(3);
        check_val("run_x", int'(pos_x), 224);
        check_val("run_anim", int'(anim_frame), 5);
        check_val("run_sprite", int'(sprite_idx), 0);

        // Pending turn waits for alignment
        do_reset();
        request(3'd1);
        tick(2);
        check_val("pre_turn_x", int'(pos_x), 226);
        avail_dir = 4'b1111;
        request(3'd2);
        tick(1);
        check_val("no_turn_dir", int'(cur_dir), 1);
        check_val("no_turn_x", int'(pos_x), 225);
        tick(1);
        check_val("no_turn_x2", int'(pos_x), 224);
        check_val("no_turn_dir2", int'(cur_dir), 1);
        tick(1);
        check_val("turn_dir", int'(cur_dir), 2);
        check_val("turn_x", int'(pos_x), 224);
        check_val("turn_y", int'(pos_y), 335);
        check_val("turn_anim", int'(anim_frame), 2);
        check_val("turn_sprite", int'(sprite_idx), 3);

        // Immediate reversal mid-tile
        do_reset();
        avail_dir = 4'b0101;
        request(3'd3);
        tick(2);
        check_val("right_x", int'(pos_x), 230);
        check_val("right_anim", int'(anim_frame), 3);
        request(3'd1);
        tick(1);
        check_val("rev_dir", int'(cur_dir), 1);
        check_val("rev_x", int'(pos_x), 229);
        check_val("rev_anim", int'(anim_frame), 2);

        // Run left to the tunnel; visible-field clip on the way
        tick(169);
        check_val("x60", int'(pos_x), 60);
        probe(70, 342, 0, "clip_left");
        probe(72, 342, 1, "clip_edge");
        tick(12);
        check_val("x48", int'(pos_x), 48);
        tick(1);
        check_val("wrap_left", int'(pos_x), 408);
        request(3'd3);
        tick(1);
        check_val("wrap_rev_x", int'(pos_x), 409);
        tick(23);
        check_val("x432", int'(pos_x), 432);
        tick(1);
        check_val("wrap_right", int'(pos_x), 48);
        check_val("wrap_y", int'(pos_y), 336);

        // Wall ahead, then freeze
        do_reset();
        request(3'd1);
        tick(2);
        check_val("pre_wall_anim", int'(anim_frame), 3);
        avail_dir = 4'b0100;
        tick(1);
        check_val("wall_x", int'(pos_x), 226);
        check_val("wall_moving", int'(moving), 0);
        check_val("wall_anim", int'(anim_frame), 2);
        check_val("wall_sprite", int'(sprite_idx), 2);
        avail_dir = 4'b0101;
        freeze = 1'b1;
        tick(2);
        check_val("frz_x", int'(pos_x), 226);
        check_val("frz_anim", int'(anim_frame), 2);
        check_val("frz_moving", int'(moving), 0);
        freeze = 1'b0;
        tick(1);
        check_val("unfrz_x", int'(pos_x), 225);
        check_val("unfrz_anim", int'(anim_frame), 3);
        check_val("unfrz_moving", int'(moving), 1);

        // Reset wins over a same-cycle tick
        @(negedge Clk) begin Reset = 1'b1; frame_tick = 1'b1; end
        @(negedge Clk) begin Reset = 1'b0; frame_tick = 1'b0; end
        check_val("rt_x", int'(pos_x), 228);
        check_val("rt_dir", int'(cur_dir), 0);
        check_val("rt_anim", int'(anim_frame), 0);
        check_val("rt_moving", int'(moving), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
